// File: rtl/percep_accum_ctrl.sv
// Sequencing controller for a perceptron's fp16 multiply-accumulate loop:
// clears the sum, admits NUM_IN products, drains the pipeline and holds the activated result.
module percep_accum_ctrl #(
   parameter int FP_WIDTH  = 16,
   parameter int NUM_IN    = 4,
   parameter int CNT_WIDTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                prod_zero,
   output logic                rst_add1,
   input  logic [FP_WIDTH-1:0] fp_sum_pip,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FP_WIDTH-1:0] sum_out,
   output logic                y_out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      ACC   = 3'd2,
      DRAIN = 3'd3,
      OUT   = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_IN - 1);

   state_t               state;
   state_t               state_next;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 drain_cnt;
   logic                 drain_next;
   logic                 capture;
   logic                 accept;
   logic                 y_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         drain_cnt <= drain_next;
      end
   end

   // Two DRAIN cycles let the last product pass the pipeline register and the adder loop register.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      drain_next = drain_cnt;
      in_ready   = 1'b0;
      rst_add1   = 1'b0;
      busy       = 1'b1;
      out_valid  = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = CLR;
            end
         end
         CLR: begin
            rst_add1   = 1'b1;
            cnt_next   = '0;
            drain_next = 1'b0;
            state_next = ACC;
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (cnt == LAST_CNT) begin
                  cnt_next   = '0;
                  drain_next = 1'b0;
                  state_next = DRAIN;
               end else begin
                  cnt_next = cnt + CNT_WIDTH'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_cnt) begin
               drain_next = 1'b0;
               capture    = 1'b1;
               state_next = OUT;
            end else begin
               drain_next = 1'b1;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Any cycle without an accepted product feeds +0 into the adder so the sum is unaffected.
   assign accept    = in_valid & in_ready;
   assign prod_zero = ~accept;

   // Step activation: strictly positive only, so both signed zeros map to 0.
   assign y_next = ~fp_sum_pip[FP_WIDTH-1] & (|fp_sum_pip[FP_WIDTH-2:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_out <= '0;
         y_out   <= 1'b0;
      end else if (capture) begin
         sum_out <= fp_sum_pip;
         y_out   <= y_next;
      end
   end

endmodule
